spi_reg_controller: RTL and testbench
=====================================

Name: spi_reg_controller

Overview:
- SPI mode-0 controller (initiator) that issues 16-bit register-access frames to our SPI register peripheral, which drives the PWM/output-enable registers.
- Accepts one command at a time over a valid/ready handshake and serialises it MSB-first on SCLK/nCS/MOSI.
- Captures MISO for the whole frame.
- Used on-chip as a loopback/self-test master and in the bench as the synthesizable bus driver.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles (>=1); SCLK = clk/(2*CLK_DIV).
- CS_SETUP, 2: cycles nCS is low before the first SCLK half-period starts (>=1).
- CS_HOLD, 2: cycles after the final SCLK fall before nCS rises (>=1).
- CS_IDLE, 2: minimum cycles nCS stays high between frames (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller can accept a command
- cmd_wr  in  1  frame bit 15: 1 = write, 0 = read
- cmd_addr  in  7  frame bits 14:8
- cmd_data  in  8  frame bits 7:0
- busy  out  1  frame in progress (any state but IDLE)
- done  out  1  one-cycle pulse at frame end
- rx_data  out  16  MISO bits of the last frame, first bit in [15]
- spi_sclk  out  1  serial clock, idle low
- spi_ncs  out  1  chip select, active low
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in

Behaviour:
- Reset (async, immediate, including mid-frame):
  - spi_ncs=1, spi_sclk=0, spi_mosi=0.
  - cmd_ready=1, busy=0, done=0, rx_data=0, state=IDLE.
  - After reset the controller is ready; the aborted frame is not resumed.
- All outputs are registered.
- FSM is IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On the clk edge where cmd_valid & cmd_ready are high, latch {cmd_wr, cmd_addr, cmd_data} into a 16-bit shift register.
  - Next cycle: spi_ncs=0, spi_mosi=bit15, cmd_ready=0, enter SETUP.
- cmd_valid without ready is ignored. Inputs are not sampled while busy.
- SETUP: CS_SETUP cycles with sclk=0, then enter SHIFT.
- SHIFT:
  - 16 bit periods. Each is CLK_DIV cycles sclk low, then CLK_DIV cycles sclk high.
  - First sclk rise is CS_SETUP+CLK_DIV cycles after nCS falls.
  - On the clk edge that drives sclk 0->1: shift spi_miso into rx shift register LSB (bit order: first sampled ends in [15]).
  - On each edge that drives sclk 1->0 (except the last): spi_mosi advances to the next bit.
  - After the 16th falling edge (sclk=0), enter HOLD.
- HOLD:
  - CS_HOLD cycles, sclk=0, mosi held.
  - Then spi_ncs=1, spi_mosi=0, rx_data<=captured word, done=1 for that one cycle; enter GAP.
- GAP: CS_IDLE cycles with nCS high, then IDLE (cmd_ready=1).
- Frame length: nCS low for exactly CS_SETUP + 32*CLK_DIV + CS_HOLD cycles (defaults: 132).
- Back-to-back: cmd_valid held high starts the next frame on the first IDLE cycle. nCS-high gap is CS_IDLE+1 cycles minimum (GAP plus the accept cycle).
- Counters:
  - Bit counter is 5 bits, 0..16, with no wrap.
  - Divider counter is sized $clog2(max(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE)+1).
- rx_data changes only at frame end. A read frame returns peripheral data in rx_data[7:0].
- No CPOL/CPHA options. No multi-byte bursts.

Test Plan:
- Reset, including rst asserted for 3 cycles at arbitrary phase -> spi_ncs=1, spi_sclk=0, spi_mosi=0, cmd_ready=1, busy=0, rx_data=0x0000.
- Write cmd_wr=1, addr=0x04, data=0xFF (defaults):
  - MOSI sampled at 16 sclk rises = 0x84FF, MSB first.
  - nCS low 132 cycles; first rise 6 cycles after nCS falls.
  - done pulses exactly once, coincident with nCS rise.
- Read cmd_wr=0, addr=0x02, MISO model drives 0x00A5 (changes on sclk fall) -> MOSI word 0x0200, rx_data=0x00A5 at done, rx_data unchanged until next done.
- Back-to-back: cmd_valid held high with 0x8001 then 0x8102:
  - Two frames, in order.
  - cmd_ready low throughout each frame.
  - nCS high >= 3 cycles between frames.
  - Exactly 2 done pulses.
- Reset mid-frame after the 5th sclk rise:
  - nCS=1 and sclk=0 with no clk edge needed.
  - After release, frame 0x8300 completes cleanly, with 16 rises and correct bits.
- CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, CS_IDLE=1 build, write 0xFFFF -> sclk period 2 cycles, nCS low 34 cycles, MOSI constant 1, done once.

Source files
------------

// File: rtl/spi_reg_controller.sv
// rtl/spi_reg_controller.sv - SPI mode-0 initiator issuing 16-bit register-access frames
//
// Accepts one {wr, addr[6:0], data[7:0]} command per cmd_valid/cmd_ready handshake
// and shifts it out MSB-first on spi_mosi while capturing spi_miso into rx_data.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   cmd_valid/ready    command handshake; ready only while IDLE
//   cmd_wr/addr/data   frame bits 15 / 14:8 / 7:0
//   busy               high in every state except IDLE
//   done               one-cycle pulse coincident with spi_ncs rising
//   rx_data            MISO word of the last completed frame, first bit in [15]
//   spi_sclk/ncs/mosi  serial clock (idle low), chip select (active low), data out
//   spi_miso           serial data in, sampled on the edge that raises spi_sclk
module spi_reg_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [6:0]  cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] rx_data,
    output logic        spi_sclk,
    output logic        spi_ncs,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       bit_cnt;
    // Bit 15 goes straight to spi_mosi at accept, so only the remaining 15 bits are kept.
    logic [14:0]      tx_rest;
    logic [15:0]      rx_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            tx_rest   <= '0;
            rx_shift  <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rx_data   <= '0;
            spi_sclk  <= 1'b0;
            spi_ncs   <= 1'b1;
            spi_mosi  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        tx_rest   <= {cmd_addr, cmd_data};
                        spi_mosi  <= cmd_wr;
                        spi_ncs   <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        bit_cnt   <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                            rx_shift <= {rx_shift[14:0], spi_miso};
                        end else begin
                            spi_sclk <= 1'b0;
                            bit_cnt  <= bit_cnt + 5'd1;
                            // The 16th fall ends shifting; mosi keeps the last bit through HOLD.
                            if (bit_cnt == 5'd15) begin
                                state <= HOLD;
                            end else begin
                                spi_mosi <= tx_rest[14];
                                tx_rest  <= {tx_rest[13:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt      <= '0;
                        spi_ncs  <= 1'b1;
                        spi_mosi <= 1'b0;
                        rx_data  <= rx_shift;
                        done     <= 1'b1;
                        state    <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == IDLE_LAST) begin
                        cnt       <= '0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_controller.sv
// tb/tb_spi_reg_controller.sv - scoreboard bench for spi_reg_controller
module tb_spi_reg_controller;

    localparam int CLK_DIV    = 4;
    localparam int CS_SETUP   = 2;
    localparam int CS_HOLD    = 2;
    localparam int CS_IDLE    = 2;
    localparam int FRAME_LOW  = CS_SETUP + 32 * CLK_DIV + CS_HOLD;
    localparam int FIRST_RISE = CS_SETUP + CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_wr = 1'b0;
    logic [6:0]  cmd_addr = '0;
    logic [7:0]  cmd_data = '0;
    logic        cmd_ready, busy, done;
    logic [15:0] rx_data;
    logic        spi_sclk, spi_ncs, spi_mosi, spi_miso;

    logic        f_valid = 1'b0;
    logic        f_ready, f_busy, f_done;
    logic [15:0] f_rx;
    logic        f_sclk, f_ncs, f_mosi;

    always #5 clk = ~clk;

    spi_reg_controller #(
        .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
    ) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .spi_sclk(spi_sclk), .spi_ncs(spi_ncs), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_reg_controller #(
        .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)
    ) u_fast (
        .clk(clk), .rst(rst), .cmd_valid(f_valid), .cmd_ready(f_ready),
        .cmd_wr(1'b1), .cmd_addr(7'h7f), .cmd_data(8'hff),
        .busy(f_busy), .done(f_done), .rx_data(f_rx),
        .spi_sclk(f_sclk), .spi_ncs(f_ncs), .spi_mosi(f_mosi), .spi_miso(1'b0)
    );

    int checks = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        logic [15:0] word;
        logic [15:0] resp;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] resp_q[$];
    int          frames_expected = 0;

    // Peripheral model: presents bit 15 when nCS falls, moves to the next bit on each sclk fall.
    logic [15:0] miso_word = '0;
    int          miso_idx = 16;

    always @(negedge spi_ncs) begin
        if (resp_q.size() > 0) miso_word = resp_q.pop_front();
        else miso_word = '0;
        miso_idx = 0;
    end

    always @(negedge spi_sclk) begin
        if (!spi_ncs) miso_idx = miso_idx + 1;
    end

    assign spi_miso = (!spi_ncs && miso_idx < 16) ? miso_word[15 - miso_idx] : 1'b0;

    // Monitor for the default-parameter instance.
    logic        prev_ncs = 1'b1;
    logic        prev_sclk = 1'b0;
    int          low_cnt = 0;
    int          high_cnt = 0;
    int          rises = 0;
    int          first_rise = -1;
    int          done_cnt = 0;
    logic [15:0] mosi_word = '0;
    logic [15:0] last_rx = '0;
    logic        frame_seen = 1'b0;
    logic        ready_bad = 1'b0;
    logic        rx_bad = 1'b0;
    logic        sclk_bad = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_ncs   = 1'b1;
            prev_sclk  = 1'b0;
            low_cnt    = 0;
            high_cnt   = 0;
            rises      = 0;
            frame_seen = 1'b0;
            last_rx    = '0;
            rx_bad     = 1'b0;
            sclk_bad   = 1'b0;
            ready_bad  = 1'b0;
        end else begin
            if (!spi_ncs && prev_ncs) begin
                if (frame_seen) chk("ncs_high_gap_min", 32'(high_cnt >= CS_IDLE + 1), 32'd1);
                low_cnt    = 0;
                rises      = 0;
                first_rise = -1;
                mosi_word  = '0;
                ready_bad  = 1'b0;
            end
            if (!spi_ncs) begin
                low_cnt++;
                if (cmd_ready || !busy) ready_bad = 1'b1;
                if (spi_sclk && !prev_sclk) begin
                    if (rises == 0) first_rise = low_cnt - 1;
                    rises++;
                    mosi_word = {mosi_word[14:0], spi_mosi};
                end
            end else begin
                high_cnt++;
                if (spi_sclk) sclk_bad = 1'b1;
            end
            if (!done && rx_data != last_rx) rx_bad = 1'b1;
            if (done) begin
                done_cnt++;
                chk("done_with_ncs_rise", 32'(spi_ncs && !prev_ncs), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("mosi_word", 32'(mosi_word), 32'(e.word));
                    chk("rx_data_at_done", 32'(rx_data), 32'(e.resp));
                    chk("ncs_low_cycles", 32'(low_cnt), 32'(FRAME_LOW));
                    chk("sclk_rises", 32'(rises), 32'd16);
                    chk("first_rise_delay", 32'(first_rise), 32'(FIRST_RISE));
                    chk("ready_low_in_frame", 32'(ready_bad), 32'd0);
                    chk("rx_stable_between_done", 32'(rx_bad), 32'd0);
                    chk("sclk_low_while_ncs_high", 32'(sclk_bad), 32'd0);
                end
                last_rx    = rx_data;
                frame_seen = 1'b1;
                high_cnt   = 1;
                rx_bad     = 1'b0;
                sclk_bad   = 1'b0;
            end
            prev_ncs  = spi_ncs;
            prev_sclk = spi_sclk;
        end
    end

    // Monitor for the minimum-parameter instance.
    int          f_low = 0;
    int          f_rises = 0;
    int          f_done_cnt = 0;
    int          f_cyc = 0;
    int          f_last_rise = 0;
    logic        f_prev_sclk = 1'b0;
    logic        f_period_bad = 1'b0;
    logic        f_mosi_bad = 1'b0;
    logic [15:0] f_word = '0;

    always @(negedge clk) begin
        f_cyc++;
        if (!rst) begin
            if (!f_ncs) begin
                f_low++;
                if (!f_mosi) f_mosi_bad = 1'b1;
                if (f_sclk && !f_prev_sclk) begin
                    if (f_rises > 0 && f_cyc - f_last_rise != 2) f_period_bad = 1'b1;
                    f_last_rise = f_cyc;
                    f_rises++;
                    f_word = {f_word[14:0], f_mosi};
                end
            end
            if (f_done) f_done_cnt++;
        end
        f_prev_sclk = f_sclk;
    end

    task automatic check_reset_state(string tag);
        chk({tag, "_ncs"}, 32'(spi_ncs), 32'd1);
        chk({tag, "_sclk"}, 32'(spi_sclk), 32'd0);
        chk({tag, "_mosi"}, 32'(spi_mosi), 32'd0);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rx"}, 32'(rx_data), 32'd0);
    endtask

    task automatic send(input logic wr, input logic [6:0] addr, input logic [7:0] data,
                        input logic [15:0] resp, input bit keep);
        exp_t e;
        int   n;
        e.word = {wr, addr, data};
        e.resp = resp;
        exp_q.push_back(e);
        resp_q.push_back(resp);
        frames_expected++;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_data  = data;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && cmd_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        int n;

        #1 rst = 1'b1;
        #1 check_reset_state("reset_initial");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("done_after_reset", 32'(done), 32'd0);
        @(negedge clk);

        // Write 0x84FF.
        d0 = done_cnt;
        send(1'b1, 7'h04, 8'hff, 16'($urandom), 1'b0);
        wait_idle();
        chk("write_done_count", 32'(done_cnt - d0), 32'd1);

        // Read addr 0x02, peripheral returns 0x00A5.
        send(1'b0, 7'h02, 8'h00, 16'h00a5, 1'b0);
        wait_idle();
        repeat (5) @(negedge clk);
        chk("read_rx_held", 32'(rx_data), 32'h00a5);

        // Back-to-back with cmd_valid held high.
        d0 = done_cnt;
        send(1'b1, 7'h00, 8'h01, 16'($urandom), 1'b1);
        send(1'b1, 7'h01, 8'h02, 16'($urandom), 1'b0);
        wait_idle();
        chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);

        // Reset for 3 cycles at an arbitrary phase.
        @(negedge clk);
        #($urandom_range(1, 8));
        rst = 1'b1;
        #1 check_reset_state("reset_phase");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-frame after the 5th sclk rise.
        send(1'b1, 7'h03, 8'h00, 16'($urandom), 1'b0);
        n = 0;
        while (rises < 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_5th_rise", 32'(rises), 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("abort_ncs_async", 32'(spi_ncs), 32'd1);
        chk("abort_sclk_async", 32'(spi_sclk), 32'd0);
        exp_q.delete();
        resp_q.delete();
        frames_expected--;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset_midframe");
        @(negedge clk);
        send(1'b1, 7'h03, 8'h00, 16'($urandom), 1'b0);
        wait_idle();

        // Randomised frames, some back-to-back.
        for (int i = 0; i < 20; i++) begin
            bit keep;
            keep = (i < 19) && ($urandom_range(0, 2) == 0);
            send(1'($urandom), 7'($urandom), 8'($urandom), 16'($urandom), keep);
            if (!keep) repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_idle();
        chk("done_total", 32'(done_cnt), 32'(frames_expected));

        // Minimum-parameter instance: write 0xFFFF.
        f_valid = 1'b1;
        n = 0;
        while (!f_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        f_valid = 1'b0;
        n = 0;
        while (f_done_cnt == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        chk("fast_ncs_low_cycles", 32'(f_low), 32'd34);
        chk("fast_rises", 32'(f_rises), 32'd16);
        chk("fast_mosi_word", 32'(f_word), 32'hffff);
        chk("fast_sclk_period", 32'(f_period_bad), 32'd0);
        chk("fast_mosi_constant", 32'(f_mosi_bad), 32'd0);
        chk("fast_done_count", 32'(f_done_cnt), 32'd1);
        chk("fast_rx", 32'(f_rx), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
